// File: rtl/fan_ctrl_multi.sv
// NUM_FANS-channel PWM/tach/stall controller; PWM and tach outputs registered, tach edge counted 3 cycles after the pin.
// No backpressure (free-running); optional FAN_FAILSAFE_EN forces all PWM high while any channel is stalled.
module fan_ctrl_multi #(
  parameter int NUM_FANS      = 1,
  parameter int PWM_BITS      = 10,
  parameter int PRESCALE      = 1,
  parameter int RPM_BITS      = 16,
  parameter int WINDOW_CYCLES = 48828 * 1024,
  parameter int STALL_WINDOWS = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_FANS*PWM_BITS-1:0] io_fan_speed,
  input  logic [NUM_FANS-1:0]          fan_tach,
  output logic [NUM_FANS-1:0]          fan_pwm,
  output logic [NUM_FANS*RPM_BITS-1:0] io_fan_rpm,
  output logic                         rpm_valid,
  output logic [NUM_FANS-1:0]          fan_stall
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int ST_W  = $clog2(STALL_WINDOWS + 1);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STALL_WINDOWS);

  logic [PS_W-1:0]     ps_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic                tick;
  logic                win_end;
  logic                force_on;

  assign tick    = (ps_cnt == PS_LAST);
  assign win_end = (win_cnt == WIN_LAST);

`ifdef FAN_FAILSAFE_EN
  assign force_on = |fan_stall;
`else
  assign force_on = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_cnt    <= '0;
      pwm_cnt   <= '0;
      win_cnt   <= '0;
      rpm_valid <= 1'b0;
    end else begin
      ps_cnt    <= tick ? '0 : ps_cnt + PS_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      win_cnt   <= win_end ? '0 : win_cnt + WIN_W'(1);
      rpm_valid <= win_end;
    end
  end

  for (genvar g = 0; g < NUM_FANS; g++) begin : g_ch
    logic [PWM_BITS-1:0] shadow;
    logic                tach_s1, tach_s2, tach_prev;
    logic                pwm_q, stall_q;
    logic [RPM_BITS-1:0] edge_cnt, rpm_q;
    logic [ST_W-1:0]     stall_cnt;
    logic                tach_edge;
    logic [RPM_BITS:0]   edge_sum;
    logic [RPM_BITS-1:0] edge_sat;
    logic [ST_W-1:0]     stall_nxt;

    assign tach_edge = tach_s2 & ~tach_prev;
    assign edge_sum  = {1'b0, edge_cnt} + {{RPM_BITS{1'b0}}, tach_edge};
    assign edge_sat  = edge_sum[RPM_BITS] ? '1 : edge_sum[RPM_BITS-1:0];

    // A window with no edges only counts toward stall while the fan is commanded on.
    always_comb begin
      stall_nxt = '0;
      if (edge_sat == '0 && shadow != '0)
        stall_nxt = (stall_cnt == ST_MAX) ? stall_cnt : stall_cnt + ST_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        shadow    <= '0;
        tach_s1   <= 1'b0;
        tach_s2   <= 1'b0;
        tach_prev <= 1'b0;
        pwm_q     <= 1'b0;
        stall_q   <= 1'b0;
        edge_cnt  <= '0;
        rpm_q     <= '0;
        stall_cnt <= '0;
      end else begin
        tach_s1   <= fan_tach[g];
        tach_s2   <= tach_s1;
        tach_prev <= tach_s2;
        if (tick && pwm_cnt == '0)
          shadow <= io_fan_speed[g*PWM_BITS +: PWM_BITS];
        pwm_q <= force_on || (pwm_cnt < shadow) || (&shadow);
        if (win_end) begin
          rpm_q     <= edge_sat;
          edge_cnt  <= '0;
          stall_cnt <= stall_nxt;
          stall_q   <= (stall_nxt == ST_MAX);
        end else begin
          edge_cnt  <= edge_sat;
        end
      end
    end

    assign fan_pwm[g]                          = pwm_q;
    assign fan_stall[g]                        = stall_q;
    assign io_fan_rpm[g*RPM_BITS +: RPM_BITS]  = rpm_q;
  end

endmodule
